text_scanout: RTL and testbench

- Downstream stage of the GPU text command processor.
- Scans the 40x25 character text RAM that the command processor fills, looks up glyphs in the 8x8 font ROM and drives 640x480@60 VGA timing plus 12-bit RGB.
- Each glyph is doubled 2x in both axes to a 16x16 cell. The text area covers lines 0..399; lines 400..479 are blank.
- Draws a blinking inverse-video cursor at the command processor's current column/row.

---
 rtl/text_scanout_if.sv | 46 ++++
 rtl/text_scanout.sv | 184 ++++++++++++++++++
 tb/tb_text_scanout.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/text_scanout_if.sv
// Memory, cursor and video bundle between text_scanout and its environment.
// master = scanout side, slave = RAM/ROM/cursor/display side.
interface text_scanout_if;
    logic [10:0] ram_addr;
    logic [7:0]  ram_data;
    logic [10:0] font_addr;
    logic [7:0]  font_data;
    logic [5:0]  cursor_x;
    logic [4:0]  cursor_y;
    logic        cursor_en;
    logic [11:0] rgb;
    logic        hsync;
    logic        vsync;
    logic        de;
    logic        vblank;

    modport master (
        output ram_addr,
        output font_addr,
        output rgb,
        output hsync,
        output vsync,
        output de,
        output vblank,
        input  ram_data,
        input  font_data,
        input  cursor_x,
        input  cursor_y,
        input  cursor_en
    );

    modport slave (
        input  ram_addr,
        input  font_addr,
        input  rgb,
        input  hsync,
        input  vsync,
        input  de,
        input  vblank,
        output ram_data,
        output font_data,
        output cursor_x,
        output cursor_y,
        output cursor_en
    );
endinterface

// File: rtl/text_scanout.sv
// 40x25 text scanout: 640x480@60 timing, 2x-doubled 8x8 glyphs, blinking cursor.
// Four register stages from counters to rgb/hsync/vsync/de/vblank.
module text_scanout #(
    parameter logic [11:0] FG_COLOR     = 12'hFFF,
    parameter logic [11:0] BG_COLOR     = 12'h000,
    parameter int          BLINK_FRAMES = 16,
    parameter bit          SYNC_POL     = 1'b0
) (
    input  logic           clk,
    input  logic           reset,
    text_scanout_if.master bus
);

    localparam logic [9:0] H_ACT  = 10'd640;
    localparam logic [9:0] H_SS   = 10'd656;
    localparam logic [9:0] H_SE   = 10'd752;
    localparam logic [9:0] H_LAST = 10'd799;
    localparam logic [9:0] V_ACT  = 10'd480;
    localparam logic [9:0] V_TXT  = 10'd400;
    localparam logic [9:0] V_SS   = 10'd490;
    localparam logic [9:0] V_SE   = 10'd492;
    localparam logic [9:0] V_LAST = 10'd524;

    localparam int FW =
        (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [FW-1:0] F_LAST = FW'(BLINK_FRAMES - 1);

    typedef struct packed {
        logic       text;
        logic       inv;
        logic [2:0] xsub;
        logic       act;
        logic       hs;
        logic       vs;
        logic       vb;
    } tag_t;

    logic [9:0]    hcnt;
    logic [9:0]    vcnt;
    logic [FW-1:0] frame_cnt;
    logic          blink_on;
    logic          h_last;
    logic          v_last;

    assign h_last = (hcnt == H_LAST);
    assign v_last = (vcnt == V_LAST);

    always_ff @(posedge clk) begin
        if (!reset) begin
            hcnt <= '0;
            vcnt <= '0;
        end else if (h_last) begin
            hcnt <= '0;
            vcnt <= v_last ? '0 : vcnt + 10'd1;
        end else begin
            hcnt <= hcnt + 10'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            frame_cnt <= '0;
            blink_on  <= 1'b0;
        end else if (h_last && v_last) begin
            if (frame_cnt == F_LAST) begin
                frame_cnt <= '0;
                blink_on  <= ~blink_on;
            end else begin
                frame_cnt <= frame_cnt + 1'b1;
            end
        end
    end

    // Stage 0: cell address and per-pixel tag from the counters
    logic        text0;
    logic [5:0]  col0;
    logic [4:0]  row0;
    logic [10:0] addr0;
    logic        hit0;
    tag_t        tag0;

    always_comb begin
        text0 = (hcnt < H_ACT) && (vcnt < V_TXT);
        col0  = hcnt[9:4];
        row0  = vcnt[8:4];
        addr0 = '0;
        if (text0) begin
            addr0 = {1'b0, row0, 5'b0}
                  + {3'b0, row0, 3'b0}
                  + {5'b0, col0};
        end
        hit0 = bus.cursor_en && blink_on && text0
            && (col0 == bus.cursor_x)
            && (row0 == bus.cursor_y);
        tag0.text = text0;
        tag0.inv  = hit0;
        tag0.xsub = hcnt[3:1];
        tag0.act  = (hcnt < H_ACT) && (vcnt < V_ACT);
        tag0.hs   = (hcnt >= H_SS) && (hcnt < H_SE);
        tag0.vs   = (vcnt >= V_SS) && (vcnt < V_SE);
        tag0.vb   = (vcnt >= V_ACT);
    end

    logic [10:0] addr_q;
    logic [2:0]  ysub_q;
    tag_t        t0;

    always_ff @(posedge clk) begin
        if (!reset) begin
            addr_q <= '0;
            ysub_q <= '0;
            t0     <= '0;
        end else begin
            addr_q <= addr0;
            ysub_q <= vcnt[3:1];
            t0     <= tag0;
        end
    end

    // Stage 1: glyph row address; non-text RAM data is masked
    logic [10:0] faddr_q;
    tag_t        t1;

    always_ff @(posedge clk) begin
        if (!reset) begin
            faddr_q <= '0;
            t1      <= '0;
        end else begin
            faddr_q <= t0.text ? {bus.ram_data, ysub_q} : '0;
            t1      <= t0;
        end
    end

    // Stage 2: pick the glyph bit and apply cursor inversion
    logic        gbit;
    logic [11:0] pix_q;
    tag_t        t2;

    assign gbit = bus.font_data[3'd7 - t1.xsub];

    always_ff @(posedge clk) begin
        if (!reset) begin
            pix_q <= '0;
            t2    <= '0;
        end else begin
            pix_q <= '0;
            if (t1.text) begin
                pix_q <= (gbit ^ t1.inv) ? FG_COLOR : BG_COLOR;
            end
            t2 <= t1;
        end
    end

    logic [11:0] rgb_q;
    logic        de_q;
    logic        hs_q;
    logic        vs_q;
    logic        vb_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            rgb_q <= '0;
            de_q  <= 1'b0;
            hs_q  <= ~SYNC_POL;
            vs_q  <= ~SYNC_POL;
            vb_q  <= 1'b0;
        end else begin
            rgb_q <= pix_q;
            de_q  <= t2.act;
            hs_q  <= t2.hs ? SYNC_POL : ~SYNC_POL;
            vs_q  <= t2.vs ? SYNC_POL : ~SYNC_POL;
            vb_q  <= t2.vb;
        end
    end

    assign bus.ram_addr  = addr_q;
    assign bus.font_addr = faddr_q;
    assign bus.rgb       = rgb_q;
    assign bus.de        = de_q;
    assign bus.hsync     = hs_q;
    assign bus.vsync     = vs_q;
    assign bus.vblank    = vb_q;

endmodule

// File: tb/tb_text_scanout.sv
// Randomised bench for text_scanout against a pixel-rule reference model.
// Counters are repositioned by deposit to reach late lines and frames quickly.
module tb_text_scanout;

    localparam logic [11:0] FG = 12'hFFF;
    localparam logic [11:0] BG = 12'h000;
    localparam int BF = 16;
    localparam int LAT = 4;

    typedef struct packed {
        logic [11:0] rgb;
        logic        de;
        logic        hs;
        logic        vs;
        logic        vb;
    } obs_t;

    localparam obs_t RST = '{rgb: 12'h000, de: 1'b0,
                             hs: 1'b1, vs: 1'b1, vb: 1'b0};

    logic clk = 1'b0;
    logic reset = 1'b0;

    always #20 clk = ~clk;

    text_scanout_if vif();

    text_scanout #(
        .FG_COLOR(FG),
        .BG_COLOR(BG),
        .BLINK_FRAMES(BF),
        .SYNC_POL(1'b0)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(vif)
    );

    logic [7:0] ram  [0:2047];
    logic [7:0] font [0:2047];

    assign vif.ram_data  = ram[vif.ram_addr];
    assign vif.font_data = font[vif.font_addr];

    int n_chk = 0;
    int n_fail = 0;
    int h = 0;
    int v = 0;
    int f = 0;
    int cx = 0;
    int cy = 0;
    bit ce = 1'b0;
    obs_t pq[$];
    int aq[$];

    function automatic obs_t model(int hh, int vv, int ff,
                                   int x, int y, bit en);
        obs_t e;
        logic [7:0] ch;
        logic [7:0] g;
        bit b;
        bit inv;
        int col;
        int row;
        col = hh / 16;
        row = vv / 16;
        e.rgb = 12'h000;
        if (hh < 640 && vv < 400) begin
            ch = ram[row * 40 + col];
            g = font[int'(ch) * 8 + (vv / 2) % 8];
            b = g[7 - (hh / 2) % 8];
            inv = en && ((ff / BF) % 2 == 1)
                && col == x && row == y;
            e.rgb = (b ^ inv) ? FG : BG;
        end
        e.de = (hh < 640 && vv < 480);
        e.hs = !(hh >= 656 && hh < 752);
        e.vs = !(vv >= 490 && vv < 492);
        e.vb = (vv >= 480);
        return e;
    endfunction

    function automatic int addr_model(int hh, int vv);
        if (hh < 640 && vv < 400)
            return (vv / 16) * 40 + hh / 16;
        return 0;
    endfunction

    task automatic chk_pix(obs_t exp_v, string tag);
        obs_t got;
        got = '{rgb: vif.rgb, de: vif.de, hs: vif.hsync,
                vs: vif.vsync, vb: vif.vblank};
        n_chk++;
        assert (got === exp_v) else begin
            n_fail++;
            $error("FAIL %s at h=%0d v=%0d: got %h need %h",
                   tag, h, v, got, exp_v);
        end
    endtask

    task automatic chk_addr(int exp_v, string tag);
        n_chk++;
        assert (vif.ram_addr === 11'(exp_v)) else begin
            n_fail++;
            $error("FAIL %s at h=%0d v=%0d: got %0d need %0d",
                   tag, h, v, vif.ram_addr, exp_v);
        end
    endtask

    task automatic step();
        if (pq.size() == LAT) chk_pix(pq.pop_front(), "pix");
        if (aq.size() == 1) chk_addr(aq.pop_front(), "addr");
        vif.cursor_x = 6'(cx);
        vif.cursor_y = 5'(cy);
        vif.cursor_en = ce;
        pq.push_back(model(h, v, f, cx, cy, ce));
        aq.push_back(addr_model(h, v));
        @(posedge clk);
        if (h == 799) begin
            h = 0;
            if (v == 524) begin
                v = 0;
                f++;
            end else begin
                v++;
            end
        end else begin
            h++;
        end
        @(negedge clk);
    endtask

    task automatic run(int n);
        repeat (n) step();
    endtask

    task automatic run_to(int nh, int nv);
        int k;
        k = 0;
        while (!(h == nh && v == nv) && k < 420000) begin
            step();
            k++;
        end
    endtask

    task automatic deposit(int nh, int nv);
        dut.hcnt = 10'(nh);
        dut.vcnt = 10'(nv);
        h = nh;
        v = nv;
    endtask

    task automatic do_reset(int n);
        reset = 1'b0;
        repeat (n) begin
            @(posedge clk);
            @(negedge clk);
            chk_pix(RST, "rst_pix");
            chk_addr(0, "rst_addr");
        end
        reset = 1'b1;
        h = 0;
        v = 0;
        f = 0;
        pq.delete();
        aq.delete();
        repeat (LAT) pq.push_back(RST);
        aq.push_back(0);
    endtask

    initial begin
        for (int i = 0; i < 2048; i++) begin
            ram[i] = 8'($urandom);
            font[i] = 8'($urandom);
        end
        ram[0] = 8'h41;
        font[8'h41 * 8] = 8'b1000_0001;
        vif.cursor_x = '0;
        vif.cursor_y = '0;
        vif.cursor_en = 1'b0;

        @(negedge clk);
        do_reset(3);
        run(1700);

        run_to(300, 2);
        do_reset(3);
        run(1700);

        deposit(80, 32);
        step();
        chk_addr(85, "addr_c5r2");
        deposit(624, 384);
        step();
        chk_addr(999, "addr_c39r24");
        run(20);
        deposit(100, 400);
        step();
        chk_addr(0, "addr_v400");
        run(8);

        deposit(0, 395);
        run(800 * 7);

        deposit(0, 478);
        run_to(100, 490);
        do_reset(1);
        run(1000);

        deposit(0, 523);
        run(1700);

        ce = 1'b1;
        cx = 3;
        cy = 1;
        deposit(700, 524);
        run(6);
        for (int i = 0; i < 2048; i++) ram[i] = 8'h00;
        for (int i = 0; i < 8; i++) font[i] = 8'h00;
        run(100);
        while (f < BF - 1) begin
            deposit(790, 524);
            run(12);
        end
        deposit(0, 16);
        run(800 * 16);
        deposit(790, 524);
        run(12);
        deposit(0, 16);
        run(800 * 16);

        cx = 40;
        deposit(0, 16);
        run(800 * 2);

        deposit(700, 523);
        run(6);
        for (int i = 0; i < 2048; i++) begin
            ram[i] = 8'($urandom);
            font[i] = 8'($urandom);
        end
        deposit(0, 0);
        for (int k = 0; k < 4000; k++) begin
            if ($urandom_range(0, 99) == 0) begin
                cx = int'($urandom_range(0, 41));
                cy = int'($urandom_range(0, 2));
                ce = 1'($urandom_range(0, 3) != 0);
            end
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
